// File: rtl/array_ctrl_seq.sv
// rtl/array_ctrl_seq.sv - run-length-bounded sequencer driving the sparse PE array enables
// Moore strobes are registered from the next state, so they track state_o cycle for cycle.
module array_ctrl_seq #(
  parameter int N           = 3,
  parameter int NUM_ADDERS  = 2,
  parameter int RUN_W       = 16,
  parameter int ADDRS_WIDTH = $clog2(N-1),
  parameter int SEL_WIDTH   = $clog2(N)
) (
  input  logic                   clk_i,
  input  logic                   f_sel_rst,
  input  logic                   soft_clr_i,
  input  logic                   load_i,
  input  logic                   ready_i,
  input  logic                   start_op_i,
  input  logic                   pause_i,
  input  logic [SEL_WIDTH-1:0]   column_num_i,
  input  logic [SEL_WIDTH-1:0]   f_sel_i,
  input  logic [NUM_ADDERS-1:0]  en_adder_i,
  input  logic [RUN_W-1:0]       run_len_i,
  output logic [2:0]             state_o,
  output logic                   wreg_wr_en_o,
  output logic                   cfg_ld_o,
  output logic                   freg_ld_o,
  output logic                   mreg_wr_en_o,
  output logic                   node_ld_o,
  output logic [NUM_ADDERS-1:0]  oreg_ld_o,
  output logic [SEL_WIDTH-1:0]   column_num_o,
  output logic [SEL_WIDTH-1:0]   f_sel_o,
  output logic [NUM_ADDERS-1:0]  en_adder_o,
  output logic [ADDRS_WIDTH-1:0] mreg_wr_addrs_o,
  output logic [ADDRS_WIDTH-1:0] mreg_rd_addrs_o,
  output logic [RUN_W-1:0]       cycle_cnt_o,
  output logic                   done_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [ADDRS_WIDTH-1:0] L_WR_TOP = ADDRS_WIDTH'(N-2);
  localparam logic [SEL_WIDTH:0]     L_N      = (SEL_WIDTH+1)'(N);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_wreg;
  logic                    r_cfg;
  logic                    r_freg;
  logic                    r_mreg;
  logic                    r_node;
  logic                    r_done;
  logic [NUM_ADDERS-1:0]   r_oreg;
  logic [SEL_WIDTH-1:0]    r_col;
  logic [SEL_WIDTH-1:0]    r_fsel;
  logic [NUM_ADDERS-1:0]   r_en;
  logic [RUN_W-1:0]        r_run_len;
  logic [ADDRS_WIDTH-1:0]  r_wr;
  logic [RUN_W-1:0]        r_cnt;
  logic                    w_tc;
  logic                    w_run_entry;
  logic [ADDRS_WIDTH-1:0]  w_wr_init;
  logic [ADDRS_WIDTH-1:0]  w_wr_step;

  // A column count of 0 or >= N starts the write pointer at slot 0.
  assign w_wr_init = ((r_col != '0) && ({1'b0, r_col} < L_N)) ?
                     ADDRS_WIDTH'(r_col - SEL_WIDTH'(1)) : '0;
  assign w_wr_step = (r_wr == '0) ? L_WR_TOP : r_wr - ADDRS_WIDTH'(1);

  // >= rather than == so a pause taken on the terminal cycle still ends the run on resume.
  assign w_tc = (r_run_len != '0) && (r_cnt >= r_run_len - RUN_W'(1));

  assign w_run_entry = (w_next == S_RUN) && ((r_state == S_READY) || (r_state == S_DONE));

  always_comb begin
    w_next = r_state;
    if (soft_clr_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (load_i) w_next = S_LOAD;
        S_LOAD:  if (ready_i && !load_i) w_next = S_READY;
        S_READY: if (start_op_i && !ready_i) w_next = S_RUN;
        S_RUN: begin
          if (pause_i)   w_next = S_PAUSE;
          else if (w_tc) w_next = S_DONE;
        end
        S_PAUSE: if (!pause_i) w_next = S_RUN;
        S_DONE: begin
          if (start_op_i)  w_next = S_RUN;
          else if (load_i) w_next = S_LOAD;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge f_sel_rst) begin
    if (f_sel_rst) begin
      r_state   <= S_IDLE;
      r_wreg    <= 1'b0;
      r_cfg     <= 1'b0;
      r_freg    <= 1'b0;
      r_mreg    <= 1'b0;
      r_node    <= 1'b0;
      r_done    <= 1'b0;
      r_oreg    <= '0;
      r_col     <= '0;
      r_fsel    <= '0;
      r_en      <= '0;
      r_run_len <= '0;
      r_wr      <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      r_wreg  <= (w_next == S_LOAD);
      r_cfg   <= (w_next == S_LOAD);
      r_freg  <= (w_next == S_READY) || (w_next == S_RUN);
      r_mreg  <= (w_next == S_RUN);
      r_node  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
      r_oreg  <= (w_next == S_RUN) ? r_en : '0;
      if (soft_clr_i) begin
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        if (r_state == S_LOAD) begin
          r_col     <= column_num_i;
          r_fsel    <= f_sel_i;
          r_en      <= en_adder_i;
          r_run_len <= run_len_i;
        end
        // The RUN cycle that hands over to PAUSE still counts as an elapsed RUN cycle.
        if (w_run_entry) begin
          r_wr  <= w_wr_init;
          r_cnt <= '0;
        end else if (r_state == S_RUN) begin
          r_wr  <= w_wr_step;
          r_cnt <= r_cnt + RUN_W'(1);
        end
      end
    end
  end

  assign state_o         = r_state;
  assign wreg_wr_en_o    = r_wreg;
  assign cfg_ld_o        = r_cfg;
  assign freg_ld_o       = r_freg;
  assign mreg_wr_en_o    = r_mreg;
  assign node_ld_o       = r_node;
  assign oreg_ld_o       = r_oreg;
  assign done_o          = r_done;
  assign column_num_o    = r_col;
  assign f_sel_o         = r_fsel;
  assign en_adder_o      = r_en;
  assign mreg_wr_addrs_o = r_wr;
  assign mreg_rd_addrs_o = (r_wr == L_WR_TOP) ? '0 : r_wr + ADDRS_WIDTH'(1);
  assign cycle_cnt_o     = r_cnt;

endmodule

// File: tb/tb_array_ctrl_seq.sv
// tb/tb_array_ctrl_seq.sv - directed bench for array_ctrl_seq at N=3 and N=5
module tb_array_ctrl_seq;

  logic        clk_i = 1'b0;
  logic        f_sel_rst, soft_clr, load, ready, start, pause;
  logic [1:0]  col, fsel, en;
  logic [15:0] run_len;
  logic [2:0]  state_o;
  logic        wreg_o, cfg_o, freg_o, mreg_o, node_o, done_o;
  logic [1:0]  oreg_o, col_o, fsel_o, en_o;
  logic [0:0]  wr_o, rd_o;
  logic [15:0] cnt_o;

  logic        b_soft_clr, b_load, b_ready, b_start, b_pause;
  logic [2:0]  b_col, b_fsel;
  logic [1:0]  b_en;
  logic [15:0] b_run_len;
  logic [2:0]  b_state_o, b_col_o, b_fsel_o;
  logic        b_wreg_o, b_cfg_o, b_freg_o, b_mreg_o, b_node_o, b_done_o;
  logic [1:0]  b_oreg_o, b_en_o, b_wr_o, b_rd_o;
  logic [15:0] b_cnt_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] e_wr3[5];
  logic [31:0] e_rd3[5];
  logic [31:0] e_wr5[6];
  logic [31:0] e_rd5[6];

  always #5 clk_i = ~clk_i;

  array_ctrl_seq #(.N(3), .NUM_ADDERS(2), .RUN_W(16)) u_dut (
    .clk_i(clk_i), .f_sel_rst(f_sel_rst), .soft_clr_i(soft_clr), .load_i(load),
    .ready_i(ready), .start_op_i(start), .pause_i(pause), .column_num_i(col),
    .f_sel_i(fsel), .en_adder_i(en), .run_len_i(run_len), .state_o(state_o),
    .wreg_wr_en_o(wreg_o), .cfg_ld_o(cfg_o), .freg_ld_o(freg_o), .mreg_wr_en_o(mreg_o),
    .node_ld_o(node_o), .oreg_ld_o(oreg_o), .column_num_o(col_o), .f_sel_o(fsel_o),
    .en_adder_o(en_o), .mreg_wr_addrs_o(wr_o), .mreg_rd_addrs_o(rd_o),
    .cycle_cnt_o(cnt_o), .done_o(done_o)
  );

  array_ctrl_seq #(.N(5), .NUM_ADDERS(2), .RUN_W(16)) u_dut5 (
    .clk_i(clk_i), .f_sel_rst(f_sel_rst), .soft_clr_i(b_soft_clr), .load_i(b_load),
    .ready_i(b_ready), .start_op_i(b_start), .pause_i(b_pause), .column_num_i(b_col),
    .f_sel_i(b_fsel), .en_adder_i(b_en), .run_len_i(b_run_len), .state_o(b_state_o),
    .wreg_wr_en_o(b_wreg_o), .cfg_ld_o(b_cfg_o), .freg_ld_o(b_freg_o), .mreg_wr_en_o(b_mreg_o),
    .node_ld_o(b_node_o), .oreg_ld_o(b_oreg_o), .column_num_o(b_col_o), .f_sel_o(b_fsel_o),
    .en_adder_o(b_en_o), .mreg_wr_addrs_o(b_wr_o), .mreg_rd_addrs_o(b_rd_o),
    .cycle_cnt_o(b_cnt_o), .done_o(b_done_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    e_wr3 = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
    e_rd3 = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    e_wr5 = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
    e_rd5 = '{32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
    f_sel_rst = 1'b1; soft_clr = 1'b0; load = 1'b0; ready = 1'b0; start = 1'b0; pause = 1'b0;
    col = 2'd0; fsel = 2'd0; en = 2'd0; run_len = 16'd0;
    b_soft_clr = 1'b0; b_load = 1'b0; b_ready = 1'b0; b_start = 1'b0; b_pause = 1'b0;
    b_col = 3'd0; b_fsel = 3'd0; b_en = 2'd0; b_run_len = 16'd0;

    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_strobes", 32'({wreg_o, cfg_o, freg_o, mreg_o, node_o, oreg_o, done_o}), 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_wr", 32'(wr_o), 32'd0);
    tick();
    f_sel_rst = 1'b0;

    // Load col=2, f_sel=1, en=11, run_len=5 over two LOAD cycles.
    load = 1'b1; col = 2'd2; fsel = 2'd1; en = 2'b11; run_len = 16'd5;
    tick();
    chk("load_state", 32'(state_o), 32'd1);
    chk("load_strobes", 32'({wreg_o, cfg_o, freg_o, mreg_o}), 32'b1100);
    tick();
    chk("load_cfg", 32'({col_o, fsel_o, en_o}), 32'({2'd2, 2'd1, 2'b11}));
    load = 1'b0; ready = 1'b1;
    tick();
    chk("ready_state", 32'(state_o), 32'd2);
    chk("ready_freg", 32'({freg_o, mreg_o}), 32'b10);
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("run_state", 32'(state_o), 32'd3);
      chk("run_cnt", 32'(cnt_o), 32'(k));
      chk("run_wr", 32'(wr_o), e_wr3[k]);
      chk("run_rd", 32'(rd_o), e_rd3[k]);
      chk("run_oreg", 32'({oreg_o, mreg_o, node_o}), 32'b1111);
      tick();
    end
    chk("done_state", 32'(state_o), 32'd5);
    chk("done_flags", 32'({done_o, mreg_o, oreg_o}), 32'b1000);

    // Start and load together in DONE: restart wins, same config.
    start = 1'b1; load = 1'b1;
    tick();
    start = 1'b0; load = 1'b0;
    chk("restart_state", 32'(state_o), 32'd3);
    chk("restart_cnt", 32'(cnt_o), 32'd0);
    chk("restart_wr", 32'(wr_o), 32'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("restart_last_run", 32'({state_o, cnt_o}), 32'({3'd3, 16'd4}));
    tick();
    chk("restart_done", 32'(state_o), 32'd5);

    // DONE + load: new config col=3, f_sel=2, en=10, run_len=6.
    load = 1'b1; col = 2'd3; fsel = 2'd2; en = 2'b10; run_len = 16'd6;
    tick();
    chk("reload_state", 32'(state_o), 32'd1);
    tick();
    chk("reload_cfg", 32'({col_o, fsel_o, en_o}), 32'({2'd3, 2'd2, 2'b10}));
    load = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("p_run0", 32'({state_o, cnt_o, wr_o, oreg_o}), 32'({3'd3, 16'd0, 1'd0, 2'b10}));
    tick();
    chk("p_run1", 32'({cnt_o, wr_o}), 32'({16'd1, 1'd1}));
    tick();
    chk("p_run2", 32'({cnt_o, wr_o}), 32'({16'd2, 1'd0}));
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("pause_state", 32'(state_o), 32'd4);
      chk("pause_frozen", 32'({cnt_o, wr_o}), 32'({16'd3, 1'd1}));
      chk("pause_strobes", 32'({oreg_o, mreg_o, node_o, freg_o, done_o}), 32'd0);
    end
    pause = 1'b0;
    tick();
    chk("resume3", 32'({state_o, cnt_o, wr_o}), 32'({3'd3, 16'd3, 1'd1}));
    tick();
    chk("resume4", 32'({state_o, cnt_o}), 32'({3'd3, 16'd4}));
    tick();
    chk("resume5", 32'({state_o, cnt_o, oreg_o}), 32'({3'd3, 16'd5, 2'b10}));
    tick();
    chk("pause_done", 32'({state_o, done_o, oreg_o}), 32'({3'd5, 1'b1, 2'b00}));

    // Soft clear in RUN.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("sc_run", 32'({state_o, cnt_o, wr_o}), 32'({3'd3, 16'd1, 1'd1}));
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    chk("sc_state", 32'(state_o), 32'd0);
    chk("sc_kept", 32'({fsel_o, col_o}), 32'({2'd2, 2'd3}));
    chk("sc_cleared", 32'({cnt_o, wr_o, mreg_o}), 32'd0);

    // Async reset between edges mid-RUN (run_len=0, unbounded).
    load = 1'b1; run_len = 16'd0;
    tick();
    load = 1'b0; ready = 1'b1;
    tick();
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ar_pre", 32'({state_o, cnt_o}), 32'({3'd3, 16'd2}));
    #2;
    f_sel_rst = 1'b1;
    #1;
    chk("ar_state", 32'(state_o), 32'd0);
    chk("ar_strobes", 32'({wreg_o, cfg_o, freg_o, mreg_o, node_o, oreg_o, done_o}), 32'd0);
    chk("ar_regs", 32'({cnt_o, fsel_o, col_o, wr_o}), 32'd0);
    tick();
    f_sel_rst = 1'b0;

    // N=5 pointer walk with col=5.
    b_load = 1'b1; b_col = 3'd5; b_en = 2'b01; b_run_len = 16'd0;
    tick();
    b_load = 1'b0; b_ready = 1'b1;
    tick();
    b_ready = 1'b0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("n5_wr", 32'(b_wr_o), e_wr5[k]);
      chk("n5_rd", 32'(b_rd_o), e_rd5[k]);
      tick();
    end

    // N=5 with illegal col=0: write pointer clamps to 0.
    b_soft_clr = 1'b1;
    tick();
    b_soft_clr = 1'b0; b_load = 1'b1; b_col = 3'd0;
    tick();
    b_load = 1'b0; b_ready = 1'b1;
    tick();
    b_ready = 1'b0; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("n5_col0", 32'({b_state_o, b_wr_o, b_oreg_o}), 32'({3'd3, 2'd0, 2'b01}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
